// File: rtl/drw_wrt_ctrl_if.sv
// rtl/drw_wrt_ctrl_if.sv - write-channel bundle between drw_wrt_ctrl and the AXI fabric / write-FIFO wrapper
//
// Purpose: groups the AW/W/B write channels plus the write-FIFO wrapper
// handshake so the controller and its peers connect through one port.
// Signals:
//   AWADDR/AWLEN/AWVALID/AWREADY  write-address channel
//   WVALID/WREADY/WLAST           write-data channel (data path lives in the wrapper)
//   BVALID/BRESP/BREADY           write-response channel
//   WVALID_I/WREADY_O             beat handshake with the write-FIFO wrapper
//   ADDR_VALID/WRT_FIN            wrapper enable and final-beat-of-job flag
// Modports: master = controller side, slave = fabric/wrapper side.
interface drw_wrt_ctrl_if;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic        WVALID;
  logic        WREADY;
  logic        WLAST;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY;
  logic        WVALID_I;
  logic        WREADY_O;
  logic        ADDR_VALID;
  logic        WRT_FIN;

  modport master (
    output AWADDR, AWLEN, AWVALID, WVALID, WLAST, BREADY, WREADY_O, ADDR_VALID, WRT_FIN,
    input  AWREADY, WREADY, BVALID, BRESP, WVALID_I
  );

  modport slave (
    input  AWADDR, AWLEN, AWVALID, WVALID, WLAST, BREADY, WREADY_O, ADDR_VALID, WRT_FIN,
    output AWREADY, WREADY, BVALID, BRESP, WVALID_I
  );
endinterface

// File: rtl/drw_wrt_ctrl.sv
// rtl/drw_wrt_ctrl.sv - 2D write-burst controller: splits a HSIZE x VSIZE job into AXI write bursts
//
// Purpose: walks VSIZE lines of HSIZE 32-bit words starting at DST_ADDR with
// a pitch of STRIDE bytes, issuing bursts of at most 16 beats per line, one
// outstanding burst at a time (ADDR -> DATA -> RESP).
// Ports:
//   ACLK, ARST            clock, asynchronous active-high reset
//   RST                   synchronous soft reset
//   START                 job request pulse (honoured in IDLE only)
//   DST_ADDR/STRIDE       job base byte address and line pitch (64-byte aligned)
//   HSIZE/VSIZE           words per line, lines per job
//   BUSY/DONE/ERR         job status; ERR is sticky until the next START
//   axi                   write channels and write-FIFO wrapper handshake
module drw_wrt_ctrl (
  input  logic           ACLK,
  input  logic           ARST,
  input  logic           RST,
  input  logic           START,
  input  logic [31:0]    DST_ADDR,
  input  logic [12:0]    STRIDE,
  input  logic [10:0]    HSIZE,
  input  logic [10:0]    VSIZE,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR,
  drw_wrt_ctrl_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_line_addr;
  logic [31:0] r_burst_addr;
  logic [12:0] r_stride;
  logic [10:0] r_hsize;
  logic [10:0] r_words_rem;   // words left in the current line, including the current burst
  logic [10:0] r_lines_rem;   // lines left in the job, including the current line
  logic [7:0]  r_beat_cnt;
  logic        r_err;
  logic        r_addr_valid;

  logic [10:0] w_burst_words;
  logic [7:0]  w_awlen;
  logic        w_w_hs;
  logic        w_wlast;
  logic        w_line_done;
  logic        w_last_line;
  logic        w_job_nonempty;
  logic [31:0] w_next_line_addr;

  logic        w_busy;
  logic        w_done;
  logic        w_awvalid;
  logic        w_wvalid;
  logic        w_wready_o;
  logic        w_bready;
  logic        w_wrt_fin;

  assign w_burst_words    = (r_words_rem > 11'd16) ? 11'd16 : r_words_rem;
  // Remaining-words is 0 outside a job, which keeps AWLEN at 0 rather than wrapping to 255.
  assign w_awlen          = (w_burst_words == 11'd0) ? 8'd0 : 8'(w_burst_words - 11'd1);
  assign w_w_hs           = (r_state == S_DATA) && axi.WVALID_I && axi.WREADY;
  assign w_wlast          = (r_state == S_DATA) && (r_beat_cnt == w_awlen);
  assign w_line_done      = (r_words_rem <= w_burst_words);
  assign w_last_line      = (r_lines_rem <= 11'd1);
  assign w_job_nonempty   = (HSIZE != 11'd0) && (VSIZE != 11'd0);
  assign w_next_line_addr = r_line_addr + {19'b0, r_stride};

  always_comb begin
    w_next     = r_state;
    w_busy     = (r_state != S_IDLE);
    w_done     = 1'b0;
    w_awvalid  = 1'b0;
    w_bready   = 1'b0;
    // Soft reset gates the wrapper handshake for the whole reset cycle, not just after the edge.
    w_wvalid   = 1'b0;
    w_wready_o = 1'b0;
    w_wrt_fin  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_next = w_job_nonempty ? S_ADDR : S_FIN;
      end
      S_ADDR: begin
        w_awvalid = 1'b1;
        if (axi.AWREADY) w_next = S_DATA;
      end
      S_DATA: begin
        w_wvalid   = axi.WVALID_I && !RST;
        w_wready_o = axi.WREADY && !RST;
        w_wrt_fin  = w_wlast && w_line_done && w_last_line;
        if (w_w_hs && w_wlast) w_next = S_RESP;
      end
      S_RESP: begin
        w_bready = 1'b1;
        if (axi.BVALID) w_next = (w_line_done && w_last_line) ? S_FIN : S_ADDR;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_state      <= S_IDLE;
      r_line_addr  <= 32'd0;
      r_burst_addr <= 32'd0;
      r_stride     <= 13'd0;
      r_hsize      <= 11'd0;
      r_words_rem  <= 11'd0;
      r_lines_rem  <= 11'd0;
      r_beat_cnt   <= 8'd0;
      r_err        <= 1'b0;
      r_addr_valid <= 1'b0;
    end else if (RST) begin
      r_state      <= S_IDLE;
      r_line_addr  <= 32'd0;
      r_burst_addr <= 32'd0;
      r_stride     <= 13'd0;
      r_hsize      <= 11'd0;
      r_words_rem  <= 11'd0;
      r_lines_rem  <= 11'd0;
      r_beat_cnt   <= 8'd0;
      r_err        <= 1'b0;
      r_addr_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_line_addr  <= DST_ADDR;
            r_burst_addr <= DST_ADDR;
            r_stride     <= STRIDE;
            r_hsize      <= HSIZE;
            r_beat_cnt   <= 8'd0;
            r_err        <= 1'b0;
            // An empty job goes straight to FIN with the counters left at zero.
            if (w_job_nonempty) begin
              r_words_rem <= HSIZE;
              r_lines_rem <= VSIZE;
            end
          end
        end
        S_ADDR: begin
          if (axi.AWREADY) r_addr_valid <= 1'b1;
        end
        S_DATA: begin
          if (w_w_hs) r_beat_cnt <= w_wlast ? 8'd0 : r_beat_cnt + 8'd1;
        end
        S_RESP: begin
          if (axi.BVALID) begin
            if (axi.BRESP != 2'b00) r_err <= 1'b1;
            if (!w_line_done) begin
              r_words_rem  <= r_words_rem - w_burst_words;
              r_burst_addr <= r_burst_addr + {19'b0, w_burst_words, 2'b00};
            end else if (!w_last_line) begin
              r_lines_rem  <= r_lines_rem - 11'd1;
              r_line_addr  <= w_next_line_addr;
              r_burst_addr <= w_next_line_addr;
              r_words_rem  <= r_hsize;
            end else begin
              // Dropping here makes ADDR_VALID low for the whole FIN cycle.
              r_words_rem  <= 11'd0;
              r_lines_rem  <= 11'd0;
              r_addr_valid <= 1'b0;
            end
          end
        end
        S_FIN: begin
          r_addr_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign BUSY           = w_busy;
  assign DONE           = w_done;
  assign ERR            = r_err;
  assign axi.AWADDR     = r_burst_addr;
  assign axi.AWLEN      = w_awlen;
  assign axi.AWVALID    = w_awvalid;
  assign axi.WVALID     = w_wvalid;
  assign axi.WREADY_O   = w_wready_o;
  assign axi.WLAST      = w_wlast;
  assign axi.BREADY     = w_bready;
  assign axi.ADDR_VALID = r_addr_valid;
  assign axi.WRT_FIN    = w_wrt_fin;

endmodule
